// File: rtl/read_channel_axi.sv
// Cache line-fill reader: one AXI4 INCR read burst per replace request, each good
// beat streamed to the data memory with its index; any errored beat retries the burst.
module read_channel_axi #(
  parameter int          CACHE_FRONTEND_ADDR_W = 32,
  parameter int          CACHE_FRONTEND_DATA_W = 32,
  parameter int          CACHE_BACKEND_ADDR_W  = CACHE_FRONTEND_ADDR_W,
  parameter int          CACHE_BACKEND_DATA_W  = CACHE_FRONTEND_DATA_W,
  parameter int          CACHE_WORD_OFF_W      = 3,
  parameter int          CACHE_AXI_ID_W        = 1,
  parameter int          CACHE_AXI_ID          = 0,
  parameter int          CACHE_AXI_LEN_W       = 8,
  parameter logic [3:0]  CACHE_AXI_CACHE_MODE  = 4'b0011,
  localparam int BE_BYTE_W  = $clog2(CACHE_BACKEND_DATA_W / 8),
  localparam int BE_RATIO_W = $clog2(CACHE_BACKEND_DATA_W / CACHE_FRONTEND_DATA_W),
  localparam int LINE2MEM_W = (CACHE_WORD_OFF_W > BE_RATIO_W) ? CACHE_WORD_OFF_W - BE_RATIO_W : 0,
  localparam int CNT_W      = (LINE2MEM_W > 0) ? LINE2MEM_W : 1,
  localparam int RADDR_W    = CACHE_FRONTEND_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
  input  logic                            ap_clk,
  input  logic                            reset,
  input  logic                            replace_valid,
  input  logic [RADDR_W-1:0]              replace_addr,
  output logic                            replace,
  output logic                            read_valid,
  output logic [CNT_W-1:0]                read_addr,
  output logic [CACHE_BACKEND_DATA_W-1:0] read_rdata,
  output logic [CACHE_AXI_ID_W-1:0]       m_axi_arid,
  output logic [CACHE_BACKEND_ADDR_W-1:0] m_axi_araddr,
  output logic [CACHE_AXI_LEN_W-1:0]      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic [3:0]                      m_axi_arqos,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [CACHE_AXI_ID_W-1:0]       m_axi_rid,
  input  logic [CACHE_BACKEND_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [1:0]                      dbg_state
);

  localparam int BEATS = 1 << LINE2MEM_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ADDRESS = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             resp_err;
  logic [CNT_W-1:0] cnt_inc;
  logic [CACHE_FRONTEND_ADDR_W-1:0] line_addr;
  logic             unused_rid;

  assign unused_rid = ^m_axi_rid;
  assign resp_err   = (m_axi_rresp != 2'b00);
  assign cnt_inc    = (LINE2MEM_W == 0) ? '0 : cnt_q + 1'b1;

  // Handshakes: a transfer happens on a cycle where both valid and ready are high.
  // arvalid stays up with a stable araddr until arready; rready is held high in READ.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (replace_valid) state_d = S_ADDRESS;
      end
      S_ADDRESS: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (m_axi_arready) state_d = S_READ;
      end
      S_READ: begin
        if (m_axi_rvalid) begin
          cnt_d = cnt_inc;
          if (resp_err) err_d = 1'b1;
          // Any errored beat in the burst re-issues the same address.
          if (m_axi_rlast) state_d = (err_q || resp_err) ? S_ADDRESS : S_END;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign line_addr     = {replace_addr, {(LINE2MEM_W + BE_BYTE_W){1'b0}}};
  assign m_axi_araddr  = CACHE_BACKEND_ADDR_W'(line_addr);
  assign m_axi_arid    = CACHE_AXI_ID_W'(CACHE_AXI_ID);
  assign m_axi_arlen   = CACHE_AXI_LEN_W'(BEATS - 1);
  assign m_axi_arsize  = 3'(BE_BYTE_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_AXI_CACHE_MODE;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  assign replace       = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_ADDRESS);
  assign m_axi_rready  = (state_q == S_READ);
  assign read_valid    = m_axi_rready && m_axi_rvalid && !resp_err;
  assign read_addr     = cnt_q;
  assign read_rdata    = m_axi_rdata;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_read_channel_axi.sv
// Directed bench for read_channel_axi: default 8-beat line and a single-beat
// (line-wide backend) instance.
module tb_read_channel_axi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Default instance: 32-bit backend, 8 beats per line
  logic        replace_valid;
  logic [26:0] replace_addr;
  logic        replace, read_valid;
  logic [2:0]  read_addr;
  logic [31:0] read_rdata;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache, arqos;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [1:0]  dbg_state;

  read_channel_axi u_dut (
    .ap_clk(clk), .reset(rst),
    .replace_valid(replace_valid), .replace_addr(replace_addr),
    .replace(replace), .read_valid(read_valid), .read_addr(read_addr), .read_rdata(read_rdata),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(1'b0), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .dbg_state(dbg_state)
  );

  // Single-beat instance: backend word covers the whole 8x32-bit line
  logic         rv1;
  logic [26:0]  ra1;
  logic         replace1, read_valid1;
  logic [0:0]   read_addr1;
  logic [255:0] read_rdata1;
  logic [0:0]   arid1;
  logic [31:0]  araddr1;
  logic [7:0]   arlen1;
  logic [2:0]   arsize1, arprot1;
  logic [1:0]   arburst1;
  logic         arlock1;
  logic [3:0]   arcache1, arqos1;
  logic         arvalid1, arready1;
  logic [255:0] rdata1;
  logic [1:0]   rresp1;
  logic         rlast1, rvalid1, rready1;
  logic [1:0]   dbg_state1;

  read_channel_axi #(.CACHE_BACKEND_DATA_W(256)) u_dut1 (
    .ap_clk(clk), .reset(rst),
    .replace_valid(rv1), .replace_addr(ra1),
    .replace(replace1), .read_valid(read_valid1), .read_addr(read_addr1), .read_rdata(read_rdata1),
    .m_axi_arid(arid1), .m_axi_araddr(araddr1), .m_axi_arlen(arlen1), .m_axi_arsize(arsize1),
    .m_axi_arburst(arburst1), .m_axi_arlock(arlock1), .m_axi_arcache(arcache1),
    .m_axi_arprot(arprot1), .m_axi_arqos(arqos1), .m_axi_arvalid(arvalid1), .m_axi_arready(arready1),
    .m_axi_rid(1'b0), .m_axi_rdata(rdata1), .m_axi_rresp(rresp1), .m_axi_rlast(rlast1),
    .m_axi_rvalid(rvalid1), .m_axi_rready(rready1), .dbg_state(dbg_state1)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    replace_valid = 1'b0; replace_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    rv1 = 1'b0; ra1 = '0; arready1 = 1'b0;
    rdata1 = '0; rresp1 = 2'b00; rlast1 = 1'b0; rvalid1 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({replace, arvalid, rready, read_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl got=%b exp=0000", {replace, arvalid, rready, read_valid});
    end
    total++;
    if ({read_addr, dbg_state} !== 5'b0) begin
      bad++; $display("FAIL reset_addr_state got=%b exp=00000", {read_addr, dbg_state});
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d;
    cyc(); replace_valid = 1'b1; replace_addr = 27'h1234; #1;
    total++;
    if ({replace, arvalid} !== 2'b00) begin
      bad++; $display("FAIL basic_idle got=%b exp=00", {replace, arvalid});
    end
    cyc(); replace_valid = 1'b0; arready = 1'b1; #1;
    total++;
    if ({replace, arvalid, rready} !== 3'b110) begin
      bad++; $display("FAIL basic_ar_ctl got=%b exp=110", {replace, arvalid, rready});
    end
    total++;
    if (araddr !== 32'h0002_4680) begin
      bad++; $display("FAIL basic_araddr got=%h exp=%h", araddr, 32'h0002_4680);
    end
    total++;
    if ({arlen, arsize, arburst} !== {8'd7, 3'd2, 2'b01}) begin
      bad++; $display("FAIL basic_arfields got=%h/%h/%h exp=7/2/1", arlen, arsize, arburst);
    end
    total++;
    if ({arid, arlock, arcache, arprot, arqos} !== {1'b0, 1'b0, 4'b0011, 3'b000, 4'b0000}) begin
      bad++; $display("FAIL basic_arconst got=%h/%h/%h/%h/%h exp=0/0/3/0/0", arid, arlock, arcache, arprot, arqos);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rresp = 2'b00;
      exp_d = 32'hD100_0000 + i; rdata = exp_d; rlast = (i == 7); #1;
      total++;
      if ({replace, rready, read_valid, arvalid} !== 4'b1110) begin
        bad++; $display("FAIL basic_beat_ctl beat=%0d got=%b exp=1110", i, {replace, rready, read_valid, arvalid});
      end
      total++;
      if (read_addr !== i[2:0]) begin
        bad++; $display("FAIL basic_read_addr got=%0d exp=%0d", read_addr, i);
      end
      total++;
      if (read_rdata !== exp_d) begin
        bad++; $display("FAIL basic_rdata got=%h exp=%h", read_rdata, exp_d);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    total++;
    if ({replace, read_valid, rready} !== 3'b100) begin
      bad++; $display("FAIL basic_end got=%b exp=100", {replace, read_valid, rready});
    end
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL basic_idle_after got=%b exp=0", replace);
    end
  endtask

  task automatic test_ar_delay();
    cyc(); replace_valid = 1'b1; replace_addr = 27'h0055;
    for (int k = 0; k < 6; k++) begin
      cyc(); replace_valid = 1'b0; arready = (k == 5); #1;
      total++;
      if ({arvalid, rready, replace} !== 3'b101) begin
        bad++; $display("FAIL ardly_ctl cyc=%0d got=%b exp=101", k, {arvalid, rready, replace});
      end
      total++;
      if (araddr !== 32'h0000_0AA0) begin
        bad++; $display("FAIL ardly_araddr cyc=%0d got=%h exp=00000aa0", k, araddr);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hD200_0000 + i; rlast = (i == 7); #1;
      total++;
      if ({read_valid, read_addr} !== {1'b1, i[2:0]}) begin
        bad++; $display("FAIL ardly_beat got=%b/%0d exp=1/%0d", read_valid, read_addr, i);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL ardly_done got=%b exp=0", replace);
    end
  endtask

  task automatic test_gaps();
    int b;
    cyc(); replace_valid = 1'b1; replace_addr = 27'h0777;
    cyc(); replace_valid = 1'b0; arready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      cyc(); arready = 1'b0; b = j / 2;
      rvalid = j[0]; rdata = 32'hD300_0000 + b; rlast = j[0] && (b == 7); #1;
      total++;
      if (read_valid !== rvalid) begin
        bad++; $display("FAIL gaps_valid cyc=%0d got=%b exp=%b", j, read_valid, rvalid);
      end
      if (rvalid) begin
        total++;
        if (read_addr !== b[2:0]) begin
          bad++; $display("FAIL gaps_read_addr got=%0d exp=%0d", read_addr, b);
        end
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    total++;
    if ({replace, read_valid} !== 2'b10) begin
      bad++; $display("FAIL gaps_end got=%b exp=10", {replace, read_valid});
    end
    cyc();
  endtask

  task automatic test_error();
    cyc(); replace_valid = 1'b1; replace_addr = 27'h0ABC;
    cyc(); replace_valid = 1'b0; arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hEE00_0000 + i;
      rresp = (i == 3) ? 2'b10 : 2'b00; rlast = (i == 7); #1;
      total++;
      if ({replace, read_valid} !== {1'b1, i != 3}) begin
        bad++; $display("FAIL err_beat beat=%0d got=%b exp=%b", i, {replace, read_valid}, {1'b1, i != 3});
      end
      total++;
      if (read_addr !== i[2:0]) begin
        bad++; $display("FAIL err_read_addr got=%0d exp=%0d", read_addr, i);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b1; #1;
    total++;
    if ({replace, arvalid, rready} !== 3'b110) begin
      bad++; $display("FAIL err_retry_ar got=%b exp=110", {replace, arvalid, rready});
    end
    total++;
    if (araddr !== 32'h0001_5780) begin
      bad++; $display("FAIL err_retry_araddr got=%h exp=00015780", araddr);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hEF00_0000 + i; rlast = (i == 7); #1;
      total++;
      if ({replace, read_valid, read_addr} !== {2'b11, i[2:0]}) begin
        bad++; $display("FAIL err_clean_beat got=%b/%b/%0d exp=1/1/%0d", replace, read_valid, read_addr, i);
      end
      total++;
      if (read_rdata !== 32'hEF00_0000 + i) begin
        bad++; $display("FAIL err_clean_rdata got=%h exp=%h", read_rdata, 32'hEF00_0000 + i);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    total++;
    if ({replace, arvalid} !== 2'b10) begin
      bad++; $display("FAIL err_end got=%b exp=10", {replace, arvalid});
    end
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL err_idle got=%b exp=0", replace);
    end
  endtask

  task automatic test_reset_mid();
    cyc(); replace_valid = 1'b1; replace_addr = 27'h0100;
    cyc(); replace_valid = 1'b0; arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hAB00_0000 + i; rlast = 1'b0;
    end
    cyc(); rvalid = 1'b1; rdata = 32'hAB00_0004; #1;
    total++;
    if (read_addr !== 3'd4) begin
      bad++; $display("FAIL rstmid_beat4 got=%0d exp=4", read_addr);
    end
    rst = 1'b1; #1;
    total++;
    if ({replace, arvalid, rready, read_valid, read_addr} !== 7'b0) begin
      bad++; $display("FAIL rstmid_outputs got=%b exp=0000000", {replace, arvalid, rready, read_valid, read_addr});
    end
    cyc(); rst = 1'b0; rvalid = 1'b0; replace_valid = 1'b1; replace_addr = 27'h0200;
    cyc(); replace_valid = 1'b0; arready = 1'b1; #1;
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_4000}) begin
      bad++; $display("FAIL rstmid_restart_ar got=%b/%h exp=1/00004000", arvalid, araddr);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hAC00_0000 + i; rlast = (i == 7); #1;
      total++;
      if ({read_valid, read_addr} !== {1'b1, i[2:0]}) begin
        bad++; $display("FAIL rstmid_refill got=%b/%0d exp=1/%0d", read_valid, read_addr, i);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL rstmid_done got=%b exp=0", replace);
    end
  endtask

  task automatic test_back_to_back();
    cyc(); replace_valid = 1'b1; replace_addr = 27'h0321; #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b exp=0", replace);
    end
    cyc(); arready = 1'b1; #1;
    total++;
    if ({replace, arvalid} !== 2'b11) begin
      bad++; $display("FAIL b2b_ar got=%b exp=11", {replace, arvalid});
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hB000_0000 + i; rlast = (i == 7); #1;
      total++;
      if ({read_valid, arvalid, read_addr} !== {2'b10, i[2:0]}) begin
        bad++; $display("FAIL b2b_beat got=%b/%b/%0d exp=1/0/%0d", read_valid, arvalid, read_addr, i);
      end
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    total++;
    if ({replace, arvalid} !== 2'b10) begin
      bad++; $display("FAIL b2b_end got=%b exp=10", {replace, arvalid});
    end
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL b2b_gap got=%b exp=0", replace);
    end
    cyc(); replace_valid = 1'b0; arready = 1'b1; #1;
    total++;
    if ({replace, arvalid} !== 2'b11) begin
      bad++; $display("FAIL b2b_second_ar got=%b exp=11", {replace, arvalid});
    end
    for (int i = 0; i < 8; i++) begin
      cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hB100_0000 + i; rlast = (i == 7);
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0;
    cyc(); #1;
    total++;
    if (replace !== 1'b0) begin
      bad++; $display("FAIL b2b_done got=%b exp=0", replace);
    end
  endtask

  task automatic test_single_beat();
    logic [255:0] exp_d;
    exp_d = {8{32'hCAFE_0001}} ^ {224'b0, 32'h0000_5A5A};
    cyc(); rv1 = 1'b1; ra1 = 27'h0042; #1;
    total++;
    if (replace1 !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b exp=0", replace1);
    end
    cyc(); rv1 = 1'b0; arready1 = 1'b1; #1;
    total++;
    if ({replace1, arvalid1, araddr1} !== {2'b11, 32'h0000_0840}) begin
      bad++; $display("FAIL single_ar got=%b/%b/%h exp=1/1/00000840", replace1, arvalid1, araddr1);
    end
    total++;
    if ({arlen1, arsize1, arburst1} !== {8'd0, 3'd5, 2'b01}) begin
      bad++; $display("FAIL single_arfields got=%h/%h/%h exp=0/5/1", arlen1, arsize1, arburst1);
    end
    cyc(); arready1 = 1'b0; rvalid1 = 1'b1; rlast1 = 1'b1; rdata1 = exp_d; #1;
    total++;
    if ({read_valid1, read_addr1} !== 2'b10) begin
      bad++; $display("FAIL single_beat got=%b/%0d exp=1/0", read_valid1, read_addr1);
    end
    total++;
    if (read_rdata1 !== exp_d) begin
      bad++; $display("FAIL single_rdata got=%h exp=%h", read_rdata1, exp_d);
    end
    cyc(); rvalid1 = 1'b0; rlast1 = 1'b0; #1;
    total++;
    if ({replace1, read_valid1} !== 2'b10) begin
      bad++; $display("FAIL single_end got=%b exp=10", {replace1, read_valid1});
    end
    cyc(); #1;
    total++;
    if (replace1 !== 1'b0) begin
      bad++; $display("FAIL single_done got=%b exp=0", replace1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_ar_delay();
    test_gaps();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_single_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
